// File: rtl/memory_unit_nb.sv
// Non-blocking load/store unit: one registered request stage toward data memory,
// an in-order tag FIFO for loads in flight and a result FIFO feeding the CDB.
module memory_unit_nb #(
  parameter int BW_PROCESSOR_DATA = 32,
  parameter int BW_ADDRESS        = 32,
  parameter int BW_TAG            = 4,
  parameter int NUM_OUTSTANDING   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_lsrsv_valid,
  output logic                           i_lsrsv_ready,
  input  logic                           i_lsrsv_opcode,
  input  logic [1:0]                     i_lsrsv_size,
  input  logic                           i_lsrsv_unsigned,
  input  logic [BW_TAG-1:0]              i_lsrsv_tag,
  input  logic [BW_ADDRESS-1:0]          i_lsrsv_rwaddr,
  input  logic [BW_PROCESSOR_DATA-1:0]   i_lsrsv_wdata,
  output logic                           o_D_mem_valid,
  input  logic                           o_D_mem_ready,
  output logic                           o_D_mem_r0w1,
  output logic [BW_ADDRESS-1:0]          o_D_mem_rwaddr,
  output logic [BW_PROCESSOR_DATA-1:0]   o_D_mem_wdata,
  output logic [BW_PROCESSOR_DATA/8-1:0] o_D_mem_wstrb,
  input  logic                           i_D_mem_rvalid,
  input  logic [BW_PROCESSOR_DATA-1:0]   i_D_mem_rdata,
  output logic                           o_cdb_valid,
  input  logic                           o_cdb_ready,
  output logic [BW_TAG-1:0]              o_cdb_tag,
  output logic [BW_PROCESSOR_DATA-1:0]   o_cdb_data,
  output logic                           o_busy
);

  localparam int SW  = BW_PROCESSOR_DATA / 8;
  localparam int OB  = $clog2(SW);
  localparam int PW  = $clog2(NUM_OUTSTANDING);
  localparam int TQW = BW_TAG + 3 + OB;
  localparam int RQW = BW_TAG + BW_PROCESSOR_DATA;
  localparam logic [PW+1:0] L_DEPTH   = (PW+2)'(NUM_OUTSTANDING);
  localparam logic [PW:0]   L_PTR_ONE = {{PW{1'b0}}, 1'b1};

  function automatic logic [BW_PROCESSOR_DATA-1:0] f_format(
    input logic [BW_PROCESSOR_DATA-1:0] d,
    input logic [1:0]                   sz,
    input logic                         uns,
    input logic [OB-1:0]                off
  );
    logic [BW_PROCESSOR_DATA-1:0] s;
    logic [BW_PROCESSOR_DATA-1:0] m;
    logic                         sign;
    int                           nb;
    s    = d >> {off, 3'b000};
    nb   = 32'd8 << sz;
    m    = ~({BW_PROCESSOR_DATA{1'b1}} << nb);
    // m & ~(m >> 1) isolates the top bit of the selected field
    sign = |(s & m & ~(m >> 1));
    f_format = (sign && !uns) ? ((s & m) | ~m) : (s & m);
  endfunction

  logic                         r_req_valid;
  logic                         r_req_r0w1;
  logic [BW_ADDRESS-1:0]        r_req_addr;
  logic [BW_PROCESSOR_DATA-1:0] r_req_wdata;
  logic [SW-1:0]                r_req_wstrb;
  logic [BW_TAG-1:0]            r_req_tag;
  logic [1:0]                   r_req_size;
  logic                         r_req_uns;
  logic [OB-1:0]                r_req_off;

  logic [TQW-1:0] r_tq [NUM_OUTSTANDING];
  logic [PW:0]    r_twr, r_trd;
  logic [RQW-1:0] r_rq [NUM_OUTSTANDING];
  logic [PW:0]    r_rwr, r_rrd;

  logic [1:0]                   w_size;
  logic [OB-1:0]                w_off;
  logic [SW-1:0]                w_strb;
  logic [BW_PROCESSOR_DATA-1:0] w_wdata;
  logic [PW:0]                  w_tcnt, w_rcnt;
  logic [PW+1:0]                w_used;
  logic                         w_acc, w_fire, w_push_t, w_pop_t, w_pop_r;
  logic [TQW-1:0]               w_thead;
  logic [RQW-1:0]               w_rhead;
  logic [BW_PROCESSOR_DATA-1:0] w_fmt;

  // Request formatting: effective size, byte offset, strobe and lane-shifted data.
  always_comb begin
    w_size = i_lsrsv_size;
    if (BW_PROCESSOR_DATA == 32 && i_lsrsv_size == 2'd3) w_size = 2'd2;
    else                                                 w_size = i_lsrsv_size;
    w_off = i_lsrsv_rwaddr[OB-1:0] & ({OB{1'b1}} << w_size);
    if (i_lsrsv_opcode) begin
      w_strb  = ~({SW{1'b1}} << (32'd1 << w_size)) << w_off;
      w_wdata = i_lsrsv_wdata << {w_off, 3'b000};
    end else begin
      w_strb  = {SW{1'b1}};
      w_wdata = {BW_PROCESSOR_DATA{1'b0}};
    end
  end

  assign w_tcnt   = r_twr - r_trd;
  assign w_rcnt   = r_rwr - r_rrd;
  assign w_used   = {1'b0, w_tcnt} + {1'b0, w_rcnt} + {{(PW+1){1'b0}}, r_req_valid & ~r_req_r0w1};
  assign i_lsrsv_ready = ~rst & (~r_req_valid | o_D_mem_ready) & (w_used < L_DEPTH);
  assign w_acc    = i_lsrsv_valid & i_lsrsv_ready;
  assign w_fire   = r_req_valid & o_D_mem_ready;
  assign w_push_t = w_fire & ~r_req_r0w1;
  assign w_pop_t  = i_D_mem_rvalid & (w_tcnt != {(PW+1){1'b0}});
  assign w_pop_r  = o_cdb_valid & o_cdb_ready;
  assign w_thead  = r_tq[r_trd[PW-1:0]];
  assign w_rhead  = r_rq[r_rrd[PW-1:0]];
  assign w_fmt    = f_format(i_D_mem_rdata, w_thead[OB+2:OB+1], w_thead[OB], w_thead[OB-1:0]);

  assign o_D_mem_valid  = r_req_valid;
  assign o_D_mem_r0w1   = r_req_r0w1;
  assign o_D_mem_rwaddr = r_req_addr;
  assign o_D_mem_wdata  = r_req_wdata;
  assign o_D_mem_wstrb  = r_req_wstrb;
  assign o_cdb_valid    = (w_rcnt != {(PW+1){1'b0}});
  assign o_cdb_tag      = w_rhead[RQW-1 -: BW_TAG];
  assign o_cdb_data     = w_rhead[BW_PROCESSOR_DATA-1:0];
  assign o_busy         = r_req_valid | (w_tcnt != {(PW+1){1'b0}}) | o_cdb_valid;

  // Request stage register: refilled on accept, emptied when memory takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_valid <= 1'b0;
      r_req_r0w1  <= 1'b0;
      r_req_addr  <= {BW_ADDRESS{1'b0}};
      r_req_wdata <= {BW_PROCESSOR_DATA{1'b0}};
      r_req_wstrb <= {SW{1'b0}};
      r_req_tag   <= {BW_TAG{1'b0}};
      r_req_size  <= 2'd0;
      r_req_uns   <= 1'b0;
      r_req_off   <= {OB{1'b0}};
    end else if (w_acc) begin
      r_req_valid <= 1'b1;
      r_req_r0w1  <= i_lsrsv_opcode;
      r_req_addr  <= {i_lsrsv_rwaddr[BW_ADDRESS-1:OB], {OB{1'b0}}};
      r_req_wdata <= w_wdata;
      r_req_wstrb <= w_strb;
      r_req_tag   <= i_lsrsv_tag;
      r_req_size  <= w_size;
      r_req_uns   <= i_lsrsv_unsigned;
      r_req_off   <= w_off;
    end else if (w_fire) begin
      r_req_valid <= 1'b0;
    end
  end

  // Tag FIFO: load metadata in issue order, popped by each memory response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_twr <= {(PW+1){1'b0}};
      r_trd <= {(PW+1){1'b0}};
      for (int i = 0; i < NUM_OUTSTANDING; i++) r_tq[i] <= {TQW{1'b0}};
    end else begin
      if (w_push_t) begin
        r_tq[r_twr[PW-1:0]] <= {r_req_tag, r_req_size, r_req_uns, r_req_off};
        r_twr <= r_twr + L_PTR_ONE;
      end
      if (w_pop_t) r_trd <= r_trd + L_PTR_ONE;
    end
  end

  // Result FIFO: formatted load data; its head drives the CDB directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rwr <= {(PW+1){1'b0}};
      r_rrd <= {(PW+1){1'b0}};
      for (int i = 0; i < NUM_OUTSTANDING; i++) r_rq[i] <= {RQW{1'b0}};
    end else begin
      if (w_pop_t) begin
        r_rq[r_rwr[PW-1:0]] <= {w_thead[TQW-1 -: BW_TAG], w_fmt};
        r_rwr <= r_rwr + L_PTR_ONE;
      end
      if (w_pop_r) r_rrd <= r_rrd + L_PTR_ONE;
    end
  end

endmodule

// File: tb/tb_memory_unit_nb.sv
// Self-checking bench for memory_unit_nb: directed scenarios plus a random phase,
// all compared against a transaction-level reference model.
module tb_memory_unit_nb;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_lsrsv_valid = 1'b0, i_lsrsv_ready;
  logic        i_lsrsv_opcode = 1'b0, i_lsrsv_unsigned = 1'b0;
  logic [1:0]  i_lsrsv_size = 2'd0;
  logic [3:0]  i_lsrsv_tag = 4'd0;
  logic [31:0] i_lsrsv_rwaddr = 32'd0, i_lsrsv_wdata = 32'd0;
  logic        o_D_mem_valid, o_D_mem_ready = 1'b0, o_D_mem_r0w1;
  logic [31:0] o_D_mem_rwaddr, o_D_mem_wdata;
  logic [3:0]  o_D_mem_wstrb;
  logic        i_D_mem_rvalid = 1'b0;
  logic [31:0] i_D_mem_rdata = 32'd0;
  logic        o_cdb_valid, o_cdb_ready = 1'b0, o_busy;
  logic [3:0]  o_cdb_tag;
  logic [31:0] o_cdb_data;

  memory_unit_nb dut (
    .clk(clk), .rst(rst),
    .i_lsrsv_valid(i_lsrsv_valid), .i_lsrsv_ready(i_lsrsv_ready),
    .i_lsrsv_opcode(i_lsrsv_opcode), .i_lsrsv_size(i_lsrsv_size),
    .i_lsrsv_unsigned(i_lsrsv_unsigned), .i_lsrsv_tag(i_lsrsv_tag),
    .i_lsrsv_rwaddr(i_lsrsv_rwaddr), .i_lsrsv_wdata(i_lsrsv_wdata),
    .o_D_mem_valid(o_D_mem_valid), .o_D_mem_ready(o_D_mem_ready),
    .o_D_mem_r0w1(o_D_mem_r0w1), .o_D_mem_rwaddr(o_D_mem_rwaddr),
    .o_D_mem_wdata(o_D_mem_wdata), .o_D_mem_wstrb(o_D_mem_wstrb),
    .i_D_mem_rvalid(i_D_mem_rvalid), .i_D_mem_rdata(i_D_mem_rdata),
    .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready),
    .o_cdb_tag(o_cdb_tag), .o_cdb_data(o_cdb_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    logic [1:0]  sz;
    bit          uns;
    logic [3:0]  tag;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
  } res_t;

  req_t stim_q[$];
  req_t req_q[$];
  req_t load_q[$];
  res_t res_q[$];
  req_t hold_r;
  bit   hold_v = 1'b0;

  int n_checks = 0, n_errors = 0;
  int mr_mode = 0, cr_mode = 0, rv_mode = 0;
  bit rand_en = 1'b0, stale_rv = 1'b0, rd_force = 1'b0;
  logic [31:0] rd_val = 32'd0;
  int acc_cnt = 0, cdb_cnt = 0;
  logic [3:0]  last_tag = 4'd0, last_strb = 4'd0;
  logic [31:0] last_data = 32'd0, last_wdata = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd3) ? 4 : (32'd1 << sz);
  endfunction

  function automatic int lane_off(input req_t r);
    int nb = nbytes(r.sz);
    return ((r.addr % 4) / nb) * nb;
  endfunction

  function automatic logic [31:0] exp_addr(input req_t r);
    return r.addr - (r.addr % 4);
  endfunction

  function automatic logic [3:0] exp_strb(input req_t r);
    int v;
    if (!r.st) return 4'hF;
    v = ((32'd1 << nbytes(r.sz)) - 1) * (32'd1 << lane_off(r));
    return v[3:0];
  endfunction

  function automatic logic [31:0] exp_wdata(input req_t r);
    return r.wdata << (8 * lane_off(r));
  endfunction

  function automatic logic [31:0] ref_load(input req_t r, input logic [31:0] rd);
    longint full, v, span;
    int nb = nbytes(r.sz);
    full = longint'({32'd0, rd});
    span = 64'sd1 << (8 * nb);
    v = (full >> (8 * lane_off(r))) % span;
    if (!r.uns && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  function automatic req_t mk(input bit st, input logic [1:0] sz, input bit uns,
                              input logic [3:0] tag, input logic [31:0] addr, input logic [31:0] wd);
    req_t r;
    r.st = st; r.sz = sz; r.uns = uns; r.tag = tag; r.addr = addr; r.wdata = wd;
    return r;
  endfunction

  task automatic cycle();
    int outst;
    req_t r;
    res_t e;
    @(negedge clk);
    check("mem_valid", o_D_mem_valid, req_q.size() > 0);
    if (o_D_mem_valid && req_q.size() > 0) begin
      r = req_q[0];
      check("mem_r0w1", o_D_mem_r0w1, r.st);
      check("mem_addr", o_D_mem_rwaddr, exp_addr(r));
      check("mem_wstrb", o_D_mem_wstrb, exp_strb(r));
      if (r.st) check("mem_wdata", o_D_mem_wdata, exp_wdata(r));
    end
    check("cdb_valid", o_cdb_valid, res_q.size() > 0);
    if (o_cdb_valid && res_q.size() > 0) begin
      check("cdb_tag", o_cdb_tag, res_q[0].tag);
      check("cdb_data", o_cdb_data, res_q[0].data);
    end
    check("busy", o_busy, req_q.size() > 0 || load_q.size() > 0 || res_q.size() > 0);

    o_D_mem_ready  = pick(mr_mode);
    o_cdb_ready    = pick(cr_mode);
    i_D_mem_rvalid = stale_rv || (load_q.size() > 0 && pick(rv_mode));
    i_D_mem_rdata  = rd_force ? rd_val : $urandom;
    if (!hold_v) begin
      if (stim_q.size() > 0) begin
        hold_r = stim_q.pop_front();
        hold_v = 1'b1;
      end else if (rand_en && $urandom_range(0, 2) != 0) begin
        hold_r = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom), $urandom, $urandom);
        hold_v = 1'b1;
      end
    end
    i_lsrsv_valid    = hold_v;
    i_lsrsv_opcode   = hold_r.st;
    i_lsrsv_size     = hold_r.sz;
    i_lsrsv_unsigned = hold_r.uns;
    i_lsrsv_tag      = hold_r.tag;
    i_lsrsv_rwaddr   = hold_r.addr;
    i_lsrsv_wdata    = hold_r.wdata;
    #1;
    outst = res_q.size() + load_q.size();
    foreach (req_q[i]) if (!req_q[i].st) outst++;
    check("lsrsv_ready", i_lsrsv_ready, (req_q.size() == 0 || o_D_mem_ready) && outst < N);

    if (o_cdb_valid && o_cdb_ready && res_q.size() > 0) begin
      last_tag  = o_cdb_tag;
      last_data = o_cdb_data;
      cdb_cnt++;
      void'(res_q.pop_front());
    end
    if (i_D_mem_rvalid && load_q.size() > 0) begin
      r = load_q.pop_front();
      e.tag  = r.tag;
      e.data = ref_load(r, i_D_mem_rdata);
      res_q.push_back(e);
    end
    if (o_D_mem_valid && o_D_mem_ready && req_q.size() > 0) begin
      r = req_q.pop_front();
      last_strb  = o_D_mem_wstrb;
      last_wdata = o_D_mem_wdata;
      if (!r.st) load_q.push_back(r);
    end
    if (hold_v && i_lsrsv_ready) begin
      req_q.push_back(hold_r);
      hold_v = 1'b0;
      acc_cnt++;
    end
  endtask

  task automatic run_idle(input int limit);
    int k = 0;
    while ((hold_v || stim_q.size() > 0 || req_q.size() > 0 || load_q.size() > 0 || res_q.size() > 0)
           && k < limit) begin
      cycle();
      k++;
    end
    check("idle_timeout", k < limit, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_mem_valid"}, o_D_mem_valid, 1'b0);
    check({tag, "_r0w1"}, o_D_mem_r0w1, 1'b0);
    check({tag, "_rwaddr"}, o_D_mem_rwaddr, 32'd0);
    check({tag, "_wdata"}, o_D_mem_wdata, 32'd0);
    check({tag, "_wstrb"}, o_D_mem_wstrb, 4'd0);
    check({tag, "_cdb_valid"}, o_cdb_valid, 1'b0);
    check({tag, "_cdb_tag"}, o_cdb_tag, 4'd0);
    check({tag, "_cdb_data"}, o_cdb_data, 32'd0);
    check({tag, "_busy"}, o_busy, 1'b0);
    check({tag, "_ready"}, i_lsrsv_ready, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outs("rst_mid");
    req_q.delete(); load_q.delete(); res_q.delete(); stim_q.delete();
    hold_v = 1'b0;
    i_lsrsv_valid = 1'b0;
    i_D_mem_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, acc0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outs("rst_init");
    rst = 1'b0;

    // Load word, response two cycles after issue, CDB one cycle after rvalid.
    mr_mode = 1; cr_mode = 1; rv_mode = 0;
    stim_q.push_back(mk(1'b0, 2'd2, 1'b0, 4'd3, 32'h100, 32'd0));
    repeat (4) cycle();
    rd_force = 1'b1; rd_val = 32'h8000_00F0; rv_mode = 1;
    cycle();
    rv_mode = 0; base = cdb_cnt;
    cycle();
    check("s25_cnt", cdb_cnt - base, 1);
    check("s25_tag", last_tag, 4'd3);
    check("s25_data", last_data, 32'h8000_00F0);

    // Byte loads at 0x103, signed then unsigned.
    rv_mode = 1; rd_val = 32'h8000_0000;
    stim_q.push_back(mk(1'b0, 2'd0, 1'b0, 4'd1, 32'h103, 32'd0));
    run_idle(50);
    check("s26_signed", last_data, 32'hFFFF_FF80);
    stim_q.push_back(mk(1'b0, 2'd0, 1'b1, 4'd2, 32'h103, 32'd0));
    run_idle(50);
    check("s26_unsigned", last_data, 32'h0000_0080);
    rd_force = 1'b0;

    // Store half: upper lanes, no CDB traffic.
    base = cdb_cnt;
    stim_q.push_back(mk(1'b1, 2'd1, 1'b0, 4'd9, 32'h102, 32'h0000_BEEF));
    run_idle(50);
    repeat (2) cycle();
    check("s27_wstrb", last_strb, 4'b1100);
    check("s27_wdata_hi", last_wdata[31:16], 16'hBEEF);
    check("s27_no_cdb", cdb_cnt - base, 0);

    // Credit exhaustion with a silent memory.
    rv_mode = 0; cr_mode = 0; acc0 = acc_cnt;
    for (int i = 0; i < 5; i++)
      stim_q.push_back(mk(1'b0, 2'd2, 1'b0, 4'(i), 32'($urandom) & 32'hFFFF_FFFC, 32'd0));
    repeat (10) cycle();
    check("s28_accepted", acc_cnt - acc0, 4);
    check("s28_ready_low", i_lsrsv_ready, 1'b0);
    rv_mode = 1; cycle(); rv_mode = 0;
    repeat (3) cycle();
    check("s28_still_low", i_lsrsv_ready, 1'b0);
    check("s28_still_4", acc_cnt - acc0, 4);
    cr_mode = 1;
    repeat (2) cycle();
    check("s28_fifth", acc_cnt - acc0, 5);
    rv_mode = 1;
    run_idle(100);

    // Back-pressured CDB with three buffered results.
    rv_mode = 0; cr_mode = 0;
    for (int i = 0; i < 3; i++)
      stim_q.push_back(mk(1'b0, 2'd2, 1'b0, 4'(5 + i), 32'($urandom) & 32'hFFFF_FFFC, 32'd0));
    repeat (6) cycle();
    rv_mode = 1;
    repeat (6) cycle();
    check("s29_head_valid", o_cdb_valid, 1'b1);
    check("s29_head_tag", o_cdb_tag, 4'd5);
    cr_mode = 1; base = cdb_cnt;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("s29_consec", cdb_cnt - base, i + 1);
      check("s29_order", last_tag, 4'(5 + i));
    end
    run_idle(50);

    // Reset with two loads in flight, stale response, then a fresh load.
    rv_mode = 0;
    stim_q.push_back(mk(1'b0, 2'd2, 1'b0, 4'd10, 32'h200, 32'd0));
    stim_q.push_back(mk(1'b0, 2'd1, 1'b1, 4'd11, 32'h206, 32'd0));
    repeat (5) cycle();
    check("s30_busy_before", o_busy, 1'b1);
    do_reset();
    base = cdb_cnt;
    stale_rv = 1'b1; cycle(); stale_rv = 1'b0;
    repeat (2) cycle();
    check("s30_no_cdb", cdb_cnt - base, 0);
    rv_mode = 1;
    stim_q.push_back(mk(1'b0, 2'd1, 1'b0, 4'd12, 32'h302, 32'd0));
    run_idle(50);
    check("s30_new_load", cdb_cnt - base, 1);
    check("s30_new_tag", last_tag, 4'd12);

    // Random traffic with random handshakes on all three interfaces.
    rand_en = 1'b1; mr_mode = 2; cr_mode = 2; rv_mode = 2;
    repeat (3000) cycle();
    rand_en = 1'b0; mr_mode = 1; cr_mode = 1;
    run_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/memory_unit_nb.md
MEMORY_UNIT_NB -- requirements
Module: memory_unit_nb

Interface
REQ-001 The module SHALL have parameter BW_PROCESSOR_DATA, default 32, which is the data width; it SHALL be 32 or 64.
REQ-002 The module SHALL have parameter BW_ADDRESS, default 32, which is the address width.
REQ-003 The module SHALL have parameter BW_TAG, default 4, which is the reservation-station tag width.
REQ-004 The module SHALL have parameter NUM_OUTSTANDING, default 4, which is the maximum number of loads in flight plus buffered results; it SHALL be a power of 2 and at least 2.
REQ-005 The module SHALL have the following ports, one per line:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- i_lsrsv_valid  in  1  request valid.
- i_lsrsv_ready  out  1  request ready.
- i_lsrsv_opcode  in  1  0 = load, 1 = store.
- i_lsrsv_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double (64-bit only).
- i_lsrsv_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- i_lsrsv_tag  in  BW_TAG  destination tag.
- i_lsrsv_rwaddr  in  BW_ADDRESS  byte address.
- i_lsrsv_wdata  in  BW_PROCESSOR_DATA  store data, right-aligned.
- o_D_mem_valid  out  1  memory request valid.
- o_D_mem_ready  in  1  memory accepts request.
- o_D_mem_r0w1  out  1  0 = read, 1 = write.
- o_D_mem_rwaddr  out  BW_ADDRESS  address aligned down to the bus width.
- o_D_mem_wdata  out  BW_PROCESSOR_DATA  store data shifted to its byte lanes.
- o_D_mem_wstrb  out  BW_PROCESSOR_DATA/8  byte-enable mask.
- i_D_mem_rvalid  in  1  read response valid; no back-pressure; responses return in order.
- i_D_mem_rdata  in  BW_PROCESSOR_DATA  read response data.
- o_cdb_valid  out  1  CDB broadcast valid.
- o_cdb_ready  in  1  CDB grant.
- o_cdb_tag  out  BW_TAG  broadcast tag.
- o_cdb_data  out  BW_PROCESSOR_DATA  formatted load result.
- o_busy  out  1  a request is held, or any load is in flight or buffered.

Function
REQ-006 A transfer on any valid/ready pair SHALL occur on each rising clk edge at which both valid and ready are 1.
- Once asserted, valid and payload SHALL hold until the transfer.
REQ-007 The module SHALL contain one request stage register that drives all o_D_mem_* outputs.
REQ-008 A request accepted at edge N SHALL present o_D_mem_valid=1 from edge N onward.
- That is, zero bubbles; the request is visible the cycle after acceptance.
REQ-009 The module SHALL maintain credits = NUM_OUTSTANDING - (loads issued but unanswered + results buffered + a load held in the stage).
REQ-010 i_lsrsv_ready SHALL equal (stage empty OR o_D_mem_ready) AND credits>0.
- It SHALL NOT depend on opcode.
REQ-011 The address SHALL be aligned down to the access size.
- Low bits below the size are cleared; misaligned requests are never faulted.
REQ-012 o_D_mem_wstrb SHALL be 2^size ones shifted left by the aligned address offset within the bus.
- For loads, the strobe is all ones.
REQ-013 On a load memory handshake, the module SHALL push {tag, size, unsigned, offset} into a tag FIFO of depth NUM_OUTSTANDING.
- A store SHALL push nothing and SHALL never produce a CDB broadcast.
REQ-014 On i_D_mem_rvalid, the module SHALL pop the tag FIFO and format the data.
- Formatting: shift right by offset*8, take 2^size bytes, extend per the unsigned flag.
- The result SHALL be pushed into a result FIFO of depth NUM_OUTSTANDING.
REQ-015 A response arriving at edge R SHALL give o_cdb_valid=1 from edge R if the result FIFO was empty.
- Broadcasts SHALL be in load issue order.
REQ-016 The result FIFO SHALL accept push and pop on the same edge.
- By the credit rule it never overflows.
REQ-017 i_D_mem_rvalid with the tag FIFO empty SHALL be ignored, with no state change.
- This condition is a simulation assertion failure.
REQ-018 When o_cdb_ready=0, o_cdb_valid, o_cdb_tag and o_cdb_data SHALL hold stable.
REQ-019 Size 3 with BW_PROCESSOR_DATA=32 SHALL be treated as size 2.
REQ-020 Counters and FIFO pointers SHALL wrap modulo NUM_OUTSTANDING.
- Occupancy SHALL be tracked with one extra pointer bit.

Reset
REQ-021 On rst=1, all state SHALL clear asynchronously.
REQ-022 The following outputs SHALL be 0 during reset: o_D_mem_valid, o_D_mem_r0w1, o_D_mem_rwaddr, o_D_mem_wdata, o_D_mem_wstrb, o_cdb_valid, o_cdb_tag, o_cdb_data and o_busy.
REQ-023 i_lsrsv_ready SHALL be 0 while rst=1 and 1 on the first cycle after release.
REQ-024 Reset mid-operation SHALL discard in-flight loads.
- Memory responses arriving after reset release with the tag FIFO empty fall under REQ-017.

Verification
REQ-025 Scenario: load word addr 0x100, tag 3, memory returns 0x8000_00F0 two cycles later.
- Required: CDB tag 3, data 0x8000_00F0, one cycle after rvalid.
REQ-026 Scenario: signed byte load at 0x103 with rdata 0x80_00_00_00.
- Required: CDB data 0xFFFF_FF80.
- With unsigned=1, required CDB data is 0x0000_0080.
REQ-027 Scenario: store half 0xBEEF at 0x102.
- Required: wstrb 4'b1100, wdata 0xBEEF_xxxx in the upper lanes, and no CDB activity.
REQ-028 Scenario: NUM_OUTSTANDING=4, memory never responds, issue 5 loads.
- Required: exactly 4 accepted, then i_lsrsv_ready=0.
- After one rvalid, ready=1 again only if o_cdb_ready drains the result.
REQ-029 Scenario: hold o_cdb_ready=0 with 3 responses returned.
- Required: tags broadcast in issue order with payload stable, then 3 consecutive broadcasts once ready=1.
REQ-030 Scenario: assert rst with 2 loads in flight, then deliver a stale rvalid.
- Required: all outputs 0, no CDB broadcast, and a new load works normally.
